rx: RTL and testbench
=====================

Name: rx

Overview:
- Asynchronous serial receiver, 8N1 frame: idle-high line, start bit 0, 8 data bits LSB first, stop bit 1.
- Receive-side counterpart of the `tx` module.
- Oversamples the serial input, samples each bit at mid-bit, and presents the received byte in parallel with a one-cycle valid strobe.
- Sits between the board serial input pin and the consuming logic (LEDs/display/loopback).

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must match the transmitter bit period. Legal range ≥4, even.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- rx_si  input  1  serial input, asynchronous to clk, idle high.
- rx_po  output  8  last correctly received byte.
- rx_valid  output  1  one-cycle pulse: rx_po updated with a new byte.
- rx_busy  output  1  frame reception in progress.
- rx_ferr  output  1  one-cycle pulse: stop bit sampled 0.
- rx_perr  output  1  one-cycle pulse: parity mismatch. Constant 0 without RX_PARITY_EN.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE.
  - rx_po=8'h00, rx_valid=0, rx_busy=0, rx_ferr=0, rx_perr=0.
  - Bit/sample counters=0.
  - Both synchronizer flops=1, so no false start out of reset.
- Reset mid-frame aborts the frame. No valid/ferr pulse is produced and rx_po is cleared.
- Input path:
  - 2-flop synchronizer on rx_si, giving 2 cycles of latency.
  - Edge detect uses the synchronized value and its previous-cycle copy.
- IDLE:
  - rx_busy=0.
  - A synchronized 1→0 transition (cycle t0) moves to START, clears the sample counter, and sets rx_busy=1 from t0+1.
  - A line held low (no 1→0 edge) never starts a frame.
- START:
  - Count CLKS_PER_BIT/2 cycles; sample at t0+CLKS_PER_BIT/2.
  - Sample=0 → DATA, bit index=0.
  - Sample=1 → glitch: back to IDLE, rx_busy=0, no other output effect.
- DATA:
  - Sample every CLKS_PER_BIT cycles, at t0+CLKS_PER_BIT/2+k·CLKS_PER_BIT for k=1..8.
  - Shift the bit into MSB of an 8-bit shift register (shift right), so LSB-first order is restored.
  - After the 8th sample → STOP (or PARITY with the feature enabled).
- STOP:
  - Sample after CLKS_PER_BIT more cycles.
  - Sample=1: rx_po←shift register and rx_valid=1 for exactly one cycle, starting the cycle after the sample edge.
  - Sample=0: rx_ferr=1 for one cycle; rx_po unchanged; rx_valid stays 0.
  - Either way: state→IDLE and rx_busy=0 in the same cycle as the pulse.
- Back-to-back frames:
  - The next start edge may arrive immediately after the stop-bit mid-point.
  - IDLE accepts it from the cycle rx_busy falls.
- Break or stuck-low after a framing error: IDLE waits for the line to return high, because a new frame requires a fresh 1→0 edge.
- rx_valid, rx_ferr and rx_perr are mutually exclusive except with the optional feature (see below).
- rx_po is stable between rx_valid pulses.

Optional Feature:
- Macro: RX_PARITY_EN.
- When defined:
  - Frame is 8E1; a PARITY state follows DATA and samples one even-parity bit.
  - STOP then follows.
  - Mismatch → rx_perr one-cycle pulse at stop-sample time, and rx_po is not updated (no rx_valid).
  - Both bad stop and bad parity → rx_ferr and rx_perr pulse together.
- When undefined:
  - No PARITY state; frame is 8N1.
  - rx_perr tied 0.

Test Plan (CLKS_PER_BIT=16, bit period 16 clk):
- rst 3 cycles then idle line 50 cycles → all outputs 0, rx_po=8'h00, no pulses.
- Drive frame 0xAC (start, 0,0,1,1,0,1,0,1, stop) → rx_busy high ~152 cycles, single rx_valid, rx_po=8'hAC, rx_ferr=0.
- Frames 0xAC then 0xDC with no idle gap → two rx_valid pulses, rx_po=8'hAC then 8'hDC.
- rx_si low for 3 cycles only → rx_busy pulses ≤9 cycles, no rx_valid/rx_ferr, rx_po unchanged.
- Frame 0xDC with stop bit driven 0 → rx_ferr single pulse, no rx_valid, rx_po keeps previous value. A subsequent good 0x55 frame is received correctly.
- rst asserted mid-data of 0xAC, released, then 0x3C sent → no pulse for the aborted frame, rx_po=8'h00 after reset, then 8'h3C. With RX_PARITY_EN, 0x3C sent with parity=1 → rx_perr pulse, no rx_valid.

Source files
------------

// File: rtl/rx.sv
// rx: asynchronous serial receiver (8N1 by default, 8E1 with RX_PARITY_EN).
//   Oversamples rx_si at CLKS_PER_BIT clocks per bit, samples each bit at
//   mid-bit and presents the received byte with a one-cycle strobe.
// Optional feature macro: RX_PARITY_EN (adds an even-parity bit before stop).
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   rx_si    in   serial input, asynchronous, idle high
//   rx_po    out  [7:0] last correctly received byte
//   rx_valid out  one-cycle pulse, rx_po updated
//   rx_busy  out  frame reception in progress
//   rx_ferr  out  one-cycle pulse, stop bit sampled 0
//   rx_perr  out  one-cycle pulse, parity mismatch (0 without RX_PARITY_EN)
module rx #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_si,
   output logic [7:0] rx_po,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       rx_ferr,
   output logic       rx_perr
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync2_q, prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    po_q, po_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          par_bad;
`ifdef RX_PARITY_EN
   logic          par_bad_q, par_bad_d;
   logic          perr_q, perr_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         // synchronizer loads idle level so reset release cannot look like a start edge
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         po_q    <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef RX_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sync1_q <= rx_si;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         po_q    <= po_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef RX_PARITY_EN
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
`endif
      end
   end

`ifdef RX_PARITY_EN
   assign par_bad = par_bad_q;
`else
   assign par_bad = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      po_d    = po_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            // only a fresh 1->0 edge starts a frame; a line stuck low is ignored
            if (prev_q && !sync2_q)
               state_d = S_START;
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = sync2_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d     = '0;
               par_bad_d = sync2_q ^ (^shift_q);
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               ferr_d  = !sync2_q;
`ifdef RX_PARITY_EN
               perr_d  = par_bad_q;
`endif
               if (sync2_q && !par_bad) begin
                  po_d    = shift_q;
                  valid_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign rx_po    = po_q;
   assign rx_valid = valid_q;
   assign rx_ferr  = ferr_q;
   assign rx_busy  = (state_q != S_IDLE);
`ifdef RX_PARITY_EN
   assign rx_perr  = perr_q;
`else
   assign rx_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_rx.sv
module tb_rx;

  localparam int CPB = 16;
`ifdef RX_PARITY_EN
  localparam int FRAME_BUSY = 168;
`else
  localparam int FRAME_BUSY = 152;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_si = 1'b1;
  logic [7:0] rx_po;
  logic       rx_valid, rx_busy, rx_ferr, rx_perr;

  int vecs = 0;
  int errs = 0;

  int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int run = 0, last_run = 0;
  logic [7:0] po_log[$];

  int vc0, fc0, pc0;

  rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_si    (rx_si),
    .rx_po    (rx_po),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .rx_ferr  (rx_ferr),
    .rx_perr  (rx_perr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else begin
      if (rx_valid) begin
        valid_cnt++;
        po_log.push_back(rx_po);
      end
      if (rx_ferr) ferr_cnt++;
      if (rx_perr) perr_cnt++;
      if (rx_busy) run++;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    rx_si = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    line(1'b0, CPB);
    for (int unsigned i = 0; i < 8; i++) line(d[i], CPB);
`ifdef RX_PARITY_EN
    line(par_b, CPB);
`else
    if (par_b === 1'bx) line(1'b1, 0);
`endif
    line(stop_b, CPB);
  endtask

  task automatic snap();
    vc0 = valid_cnt;
    fc0 = ferr_cnt;
    pc0 = perr_cnt;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_po", rx_po, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    chk("rst_ferr", rx_ferr, 1'b0);
    chk("rst_perr", rx_perr, 1'b0);
    rst = 1'b0;
    line(1'b1, 50);
    chk("idle_valid_cnt", valid_cnt, 0);
    chk("idle_ferr_cnt", ferr_cnt, 0);
    chk("idle_busy", rx_busy, 1'b0);

    snap();
    send_frame(8'hAC, 1'b1, ^8'hAC);
    line(1'b1, 20);
    chk("ac_valid_pulses", valid_cnt - vc0, 1);
    chk("ac_po", rx_po, 8'hAC);
    chk("ac_ferr_pulses", ferr_cnt - fc0, 0);
    chk("ac_busy_len", last_run, FRAME_BUSY);

    snap();
    send_frame(8'hAC, 1'b1, ^8'hAC);
    send_frame(8'hDC, 1'b1, ^8'hDC);
    line(1'b1, 20);
    chk("b2b_valid_pulses", valid_cnt - vc0, 2);
    chk("b2b_first", po_log[vc0], 8'hAC);
    chk("b2b_second", po_log[vc0 + 1], 8'hDC);
    chk("b2b_po", rx_po, 8'hDC);

    snap();
    line(1'b0, 3);
    line(1'b1, 30);
    chk("glitch_busy_len", last_run, 8);
    chk("glitch_valid_pulses", valid_cnt - vc0, 0);
    chk("glitch_ferr_pulses", ferr_cnt - fc0, 0);
    chk("glitch_po", rx_po, 8'hDC);

    snap();
    send_frame(8'hDC, 1'b0, ^8'hDC);
    line(1'b0, 60);
    chk("ferr_pulses", ferr_cnt - fc0, 1);
    chk("ferr_valid_pulses", valid_cnt - vc0, 0);
    chk("ferr_po", rx_po, 8'hDC);
    chk("stuck_low_busy", rx_busy, 1'b0);
    line(1'b1, 30);
    snap();
    send_frame(8'h55, 1'b1, ^8'h55);
    line(1'b1, 20);
    chk("f55_valid_pulses", valid_cnt - vc0, 1);
    chk("f55_po", rx_po, 8'h55);

    snap();
    line(1'b0, CPB);
    for (int unsigned i = 0; i < 4; i++) line(((8'hAC >> i) & 8'h01) != 0, CPB);
    rst = 1'b1;
    line(1'b1, 3);
    chk("abort_po", rx_po, 8'h00);
    chk("abort_busy", rx_busy, 1'b0);
    rst = 1'b0;
    line(1'b1, 30);
    chk("abort_valid_pulses", valid_cnt - vc0, 0);
    chk("abort_ferr_pulses", ferr_cnt - fc0, 0);
    snap();
    send_frame(8'h3C, 1'b1, ^8'h3C);
    line(1'b1, 20);
    chk("f3c_valid_pulses", valid_cnt - vc0, 1);
    chk("f3c_po", rx_po, 8'h3C);

`ifdef RX_PARITY_EN
    snap();
    send_frame(8'h3C, 1'b1, 1'b1);
    line(1'b1, 20);
    chk("par_perr_pulses", perr_cnt - pc0, 1);
    chk("par_valid_pulses", valid_cnt - vc0, 0);
    chk("par_ferr_pulses", ferr_cnt - fc0, 0);
`else
    chk("perr_never", perr_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
